// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts until req_last or MAX_BURST beats; one arbitration cycle separates grants.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wen,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   input  logic                          fifo_full,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);

   typedef enum logic [0:0] {StIdle, StLock} state_t;

   state_t              state_q;
   logic [ID_WIDTH-1:0] rr_ptr_q;
   logic [ID_WIDTH-1:0] grant_id_q;
   logic [CntWidth-1:0] beat_cnt_q;

   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   cand;
   logic                  win_found;
   int unsigned           scan_idx;
   logic                  g_valid;
   logic                  g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic                  release_grant;

   // Scan from rr_ptr+1 upward with an explicit wrap so non-power-of-two NUM_REQ works.
   always_comb begin
      winner    = '0;
      cand      = '0;
      win_found = 1'b0;
      scan_idx  = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx = 32'(rr_ptr_q) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         cand = ID_WIDTH'(scan_idx);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            winner    = cand;
         end
      end
   end

   assign g_valid = req_valid[grant_id_q];
   assign g_last  = req_last[grant_id_q];
   assign g_data  = req_data[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      req_ready  = '0;
      fifo_wen   = 1'b0;
      fifo_wdata = '0;
      if (state_q == StLock) begin
         req_ready[grant_id_q] = !fifo_full;
         fifo_wen              = g_valid && !fifo_full;
         if (fifo_wen) begin
            fifo_wdata = g_data;
         end
      end
   end

   assign release_grant = g_last || (beat_cnt_q == CntWidth'(MAX_BURST - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
         grant_id_q <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q    <= StLock;
                  grant_id_q <= winner;
                  rr_ptr_q   <= winner;
                  beat_cnt_q <= '0;
               end
            end
            StLock: begin
               // fifo_wen is exactly the grantee's valid && ready handshake.
               if (fifo_wen) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (release_grant) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q == StLock);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance
// driven by queued packet sources; a negedge monitor checks every FIFO write.
module tb_fifo_wr_arbiter;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [3:0]      valid4, last4, ready4, en4;
   logic [4*DW-1:0] data4;
   logic            wen4, full4, busy4;
   logic [DW-1:0]   wdata4;
   logic [1:0]      gid4;

   logic [2:0]      valid3, last3, ready3, en3;
   logic [3*DW-1:0] data3;
   logic            wen3, full3, busy3;
   logic [DW-1:0]   wdata3;
   logic [1:0]      gid3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      int id;
      int data;
      int gap;
   } exp_t;

   beat_t src4 [4][$];
   beat_t src3 [3][$];
   exp_t  exp4 [$];
   exp_t  exp3 [$];

   int n_run  = 0;
   int n_fail = 0;
   int cycle  = 0;
   int last_wr4 = 0;
   int last_wr3 = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .MAX_BURST(8)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (valid4),
      .req_data   (data4),
      .req_last   (last4),
      .req_ready  (ready4),
      .fifo_wen   (wen4),
      .fifo_wdata (wdata4),
      .fifo_full  (full4),
      .grant_id   (gid4),
      .busy       (busy4)
   );

   fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(8)) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (valid3),
      .req_data   (data3),
      .req_last   (last3),
      .req_ready  (ready3),
      .fifo_wen   (wen3),
      .fifo_wdata (wdata3),
      .fifo_full  (full3),
      .grant_id   (gid3),
      .busy       (busy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_run++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         valid4[i]          = en4[i] && (src4[i].size() > 0);
         data4[i*DW +: DW]  = (src4[i].size() > 0) ? src4[i][0].data : '0;
         last4[i]           = (src4[i].size() > 0) ? src4[i][0].last : 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         valid3[i]          = en3[i] && (src3[i].size() > 0);
         data3[i*DW +: DW]  = (src3[i].size() > 0) ? src3[i][0].data : '0;
         last3[i]           = (src3[i].size() > 0) ? src3[i][0].last : 1'b0;
      end
   endtask

   // One clock cycle: handshakes are captured mid-cycle, sources advance after the edge.
   task automatic step();
      logic [3:0] f4;
      logic [2:0] f3;
      drive();
      @(negedge clk);
      f4 = valid4 & ready4;
      f3 = valid3 & ready3;
      @(posedge clk);
      cycle++;
      #1;
      if (!rst) begin
         for (int i = 0; i < 4; i++) if (f4[i]) void'(src4[i].pop_front());
         for (int i = 0; i < 3; i++) if (f3[i]) void'(src3[i].pop_front());
      end
      drive();
   endtask

   task automatic load4(input int port, input int base, input int n);
      for (int k = 0; k < n; k++) src4[port].push_back({8'(base + k), k == n - 1});
   endtask

   task automatic load3(input int port, input int base, input int n);
      for (int k = 0; k < n; k++) src3[port].push_back({8'(base + k), k == n - 1});
   endtask

   task automatic expect4(input int id, input int base, input int first, input int n,
                          input int gap0);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.id   = id;
         e.data = (base + first + k) & 8'hff;
         e.gap  = (k == 0) ? gap0 : 1;
         exp4.push_back(e);
      end
   endtask

   task automatic expect3(input int id, input int data, input int gap);
      exp_t e;
      e.id   = id;
      e.data = data;
      e.gap  = gap;
      exp3.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp4.size() > 0 || exp3.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_pending", 32'(exp4.size() + exp3.size()), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && wen4) begin
         if (exp4.size() == 0) begin
            chk("dut4_unexpected_write", {24'd0, wdata4}, 32'hffff_ffff);
         end else begin
            e = exp4.pop_front();
            chk("dut4_wdata", {24'd0, wdata4}, e.data);
            chk("dut4_grant_id", {30'd0, gid4}, e.id);
            chk("dut4_ready_onehot", {28'd0, ready4}, 32'd1 << e.id);
            if (e.gap != 0) chk("dut4_write_gap", cycle - last_wr4, e.gap);
         end
         last_wr4 = cycle;
      end
      if (!rst && wen3) begin
         if (exp3.size() == 0) begin
            chk("dut3_unexpected_write", {24'd0, wdata3}, 32'hffff_ffff);
         end else begin
            e = exp3.pop_front();
            chk("dut3_wdata", {24'd0, wdata3}, e.data);
            chk("dut3_grant_id", {30'd0, gid3}, e.id);
            if (e.gap != 0) chk("dut3_write_gap", cycle - last_wr3, e.gap);
         end
         last_wr3 = cycle;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      en4   = '0;
      en3   = '0;
      full4 = 1'b0;
      full3 = 1'b0;
      drive();

      // Reset and idle with no requests
      step();
      step();
      chk("rst_busy", busy4, 0);
      chk("rst_grant_id", gid4, 0);
      chk("rst_wen", wen4, 0);
      chk("rst_ready", ready4, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_busy", busy4, 0);
         chk("idle_wen", wen4, 0);
         chk("idle_ready", ready4, 0);
      end

      // Single-beat packets on all ports: 0,1,2,3,0 with one write every 2 cycles
      en4 = 4'hf;
      for (int i = 0; i < 4; i++) begin
         load4(i, 'h10 + i, 1);
         expect4(i, 'h10 + i, 0, 1, (i == 0) ? 0 : 2);
      end
      load4(0, 'h50, 1);
      expect4(0, 'h50, 0, 1, 2);
      wait_drain(40);

      // 12-beat packet on port 1 is split at MAX_BURST; port 2 served in between
      load4(1, 'h20, 12);
      load4(2, 'h40, 3);
      expect4(1, 'h20, 0, 8, 0);
      expect4(2, 'h40, 0, 3, 2);
      expect4(1, 'h20, 8, 4, 2);
      wait_drain(60);

      // fifo_full stalls port 0 for 3 cycles; burst counting must freeze
      load4(0, 'h60, 10);
      expect4(0, 'h60, 0, 2, 0);
      expect4(0, 'h60, 2, 6, 4);
      expect4(0, 'h60, 8, 2, 2);
      step();
      step();
      step();
      full4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive();
         #1;
         chk("full_wen", wen4, 0);
         chk("full_ready", ready4, 0);
         chk("full_busy", busy4, 1);
         step();
      end
      full4 = 1'b0;
      wait_drain(60);

      // Port 3 drops valid mid-packet; grant is held against waiting port 0
      load4(3, 'h70, 4);
      load4(0, 'h80, 1);
      expect4(3, 'h70, 0, 2, 0);
      expect4(3, 'h70, 2, 2, 3);
      expect4(0, 'h80, 0, 1, 2);
      step();
      step();
      step();
      en4[3] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive();
         #1;
         chk("hold_busy", busy4, 1);
         chk("hold_grant_id", gid4, 3);
         chk("hold_ready0", ready4[0], 0);
         chk("hold_wen", wen4, 0);
         step();
      end
      en4[3] = 1'b1;
      wait_drain(40);

      // Reset mid-LOCK abandons the grant; rr_ptr restarts so port 1 beats port 3
      load4(1, 'h90, 3);
      expect4(1, 'h90, 0, 1, 0);
      step();
      step();
      en4[1] = 1'b0;
      step();
      chk("pre_rst_busy", busy4, 1);
      chk("pre_rst_grant_id", gid4, 1);
      rst = 1'b1;
      step();
      chk("mid_rst_busy", busy4, 0);
      chk("mid_rst_grant_id", gid4, 0);
      chk("mid_rst_wen", wen4, 0);
      rst = 1'b0;
      en4 = 4'hf;
      load4(3, 'ha3, 1);
      expect4(1, 'h90, 1, 2, 0);
      expect4(3, 'ha3, 0, 1, 2);
      wait_drain(40);

      // NUM_REQ=3 wrap-around: after a grant to 2, port 0 wins before port 2
      en3 = 3'b111;
      load3(2, 'hc2, 1);
      expect3(2, 'hc2, 0);
      expect3(0, 'hd0, 2);
      expect3(2, 'hd2, 2);
      step();
      load3(0, 'hd0, 1);
      load3(2, 'hd2, 1);
      wait_drain(40);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
